// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory bus arbiter: FSM encodings,
// enable-level constants and the default bus watchdog limit.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_DATA = 2'd1,
    ARB_INST = 2'd2
  } arb_state_t;

  localparam logic        RstEnable         = 1'b1;
  localparam logic        ChipEnable        = 1'b1;
  localparam logic        WriteEnable       = 1'b1;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam int          TimeoutCycDefault = 255;

endpackage

// File: rtl/mem_bus_result_reg.sv
// Per-requester result holder: read data plus a one-shot valid flag that
// the pipeline consumes on the first non-held edge after it is set.
module mem_bus_result_reg
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_data,
  input  logic [DATA_W-1:0] data,
  input  logic              flush,
  input  logic              hold,
  output logic [DATA_W-1:0] rdata,
  output logic              valid
);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      rdata <= '0;
      valid <= 1'b0;
    end else begin
      // Stores set valid without touching the data register.
      if (load && load_data) begin
        rdata <= data;
      end
      if (flush) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
      end else if (!hold) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one multi-cycle memory bus between instruction fetch and the
// MEM load/store port. Optional bus watchdog: MEM_BUS_ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = TimeoutCycDefault
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_ce_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_stallreq_o,
  input  logic                mem_ce_i,
  input  logic                mem_we_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_stallreq_o,
  input  logic                pipe_hold_i,
  input  logic                flush_i,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  input  logic                bus_ack_i,
  output logic                bus_err_o
);

  arb_state_t state, state_next;

  logic if_valid, mem_valid;
  logic if_pending, mem_pending;
  logic grant_data, grant_inst;
  logic xfer_end, timeout_hit;
  logic discard;
  logic result_ok;
  logic [DATA_W-1:0] result_data;

  assign mem_pending = (mem_ce_i == ChipEnable) && !mem_valid;
  assign if_pending  = (if_ce_i == ChipEnable) && !if_valid;

  assign mem_stallreq_o = mem_ce_i & ~mem_valid;
  assign if_stallreq_o  = if_ce_i & ~if_valid;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // MEM wins ties because it carries the older instruction.
  always_comb begin
    state_next = state;
    grant_data = 1'b0;
    grant_inst = 1'b0;
    xfer_end   = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (mem_pending) begin
          state_next = ARB_DATA;
          grant_data = 1'b1;
        end else if (if_pending) begin
          state_next = ARB_INST;
          grant_inst = 1'b1;
        end
      end
      ARB_DATA, ARB_INST: begin
        if (bus_ack_i || timeout_hit) begin
          state_next = ARB_IDLE;
          xfer_end   = 1'b1;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
    end else if (grant_data) begin
      bus_req_o   <= 1'b1;
      bus_we_o    <= (mem_we_i == WriteEnable);
      bus_sel_o   <= mem_sel_i;
      bus_addr_o  <= mem_addr_i;
      bus_wdata_o <= mem_wdata_i;
    end else if (grant_inst) begin
      bus_req_o   <= 1'b1;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '1;
      bus_addr_o  <= if_addr_i;
      bus_wdata_o <= '0;
    end else if (xfer_end) begin
      bus_req_o   <= 1'b0;
    end
  end

  // A flushed transfer keeps the bus until ack (a store must still land),
  // but its result is dropped.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      discard <= 1'b0;
    end else if (xfer_end) begin
      discard <= 1'b0;
    end else if (flush_i && (state != ARB_IDLE)) begin
      discard <= 1'b1;
    end
  end

  assign result_ok   = xfer_end && !discard && !flush_i;
  assign result_data = bus_ack_i ? bus_rdata_i : '0;

  mem_bus_result_reg #(.DATA_W(DATA_W)) u_mem_result (
    .clk       (clk),
    .rst       (rst),
    .load      (result_ok && (state == ARB_DATA)),
    .load_data (!bus_we_o || !bus_ack_i),
    .data      (result_data),
    .flush     (flush_i),
    .hold      (pipe_hold_i),
    .rdata     (mem_rdata_o),
    .valid     (mem_valid)
  );

  mem_bus_result_reg #(.DATA_W(DATA_W)) u_if_result (
    .clk       (clk),
    .rst       (rst),
    .load      (result_ok && (state == ARB_INST)),
    .load_data (1'b1),
    .data      (result_data),
    .flush     (flush_i),
    .hold      (pipe_hold_i),
    .rdata     (if_rdata_o),
    .valid     (if_valid)
  );

`ifdef MEM_BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // wait_cnt is 0 in the first bus cycle, so the limit hits after TIMEOUT_CYC cycles.
  assign timeout_hit = (state != ARB_IDLE) && !bus_ack_i &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (grant_data || grant_inst) begin
        wait_cnt <= '0;
      end else if (state != ARB_IDLE) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign bus_err_o = err_q;
`else
  assign timeout_hit = 1'b0;
  // Keeps TIMEOUT_CYC referenced in builds without the watchdog.
  assign bus_err_o   = 1'b0 && (TIMEOUT_CYC != 0);
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; the watchdog scenario
// follows MEM_BUS_ARB_TIMEOUT_EN with TIMEOUT_CYC = 4.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce, mem_ce, mem_we, pipe_hold, flush, bus_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [3:0]  mem_sel;
  logic [31:0] if_rdata_o, mem_rdata_o, bus_addr_o, bus_wdata_o;
  logic        if_stallreq_o, mem_stallreq_o, bus_req_o, bus_we_o, bus_err_o;
  logic [3:0]  bus_sel_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_ce_i        (if_ce),
    .if_addr_i      (if_addr),
    .if_rdata_o     (if_rdata_o),
    .if_stallreq_o  (if_stallreq_o),
    .mem_ce_i       (mem_ce),
    .mem_we_i       (mem_we),
    .mem_sel_i      (mem_sel),
    .mem_addr_i     (mem_addr),
    .mem_wdata_i    (mem_wdata),
    .mem_rdata_o    (mem_rdata_o),
    .mem_stallreq_o (mem_stallreq_o),
    .pipe_hold_i    (pipe_hold),
    .flush_i        (flush),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_sel_o      (bus_sel_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_rdata_i    (bus_rdata),
    .bus_ack_i      (bus_ack),
    .bus_err_o      (bus_err_o)
  );

  // Outputs are sampled and inputs driven 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_ce = 0; mem_ce = 0; mem_we = 0; pipe_hold = 0; flush = 0; bus_ack = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; bus_rdata = 0; mem_sel = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    tick(); tick();
    checks++;
    if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got req=%b we=%b sel=%h addr=%h wdata=%h err=%b, expected all 0",
               bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o);
    end
    checks++;
    if ({if_rdata_o, mem_rdata_o} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got if=%h mem=%h, expected 0", if_rdata_o, mem_rdata_o);
    end
    checks++;
    if ({if_stallreq_o, mem_stallreq_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_stall: got %b, expected 00", {if_stallreq_o, mem_stallreq_o});
    end
    rst = 0;
    tick();
    // Reset in the middle of a fetch, then a late ack
    if_ce = 1; if_addr = 32'h0000_0500;
    tick();
    checks++;
    if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h0000_0500}) begin
      errors++;
      $display("FAIL reset_pre_grant: got req=%b addr=%h, expected 1 00000500", bus_req_o, bus_addr_o);
    end
    rst = 1;
    tick();
    checks++;
    if ({bus_req_o, bus_addr_o} !== 33'h0) begin
      errors++;
      $display("FAIL reset_abandon: got req=%b addr=%h, expected 0 0", bus_req_o, bus_addr_o);
    end
    rst = 0; if_ce = 0; bus_ack = 1; bus_rdata = 32'h5555_AAAA;
    tick();
    bus_ack = 0;
    checks++;
    if ({bus_req_o, if_rdata_o} !== 33'h0) begin
      errors++;
      $display("FAIL reset_late_ack: got req=%b if_rdata=%h, expected 0 0", bus_req_o, if_rdata_o);
    end
  endtask

  task automatic test_lone_fetch();
    int stall_cycles;
    stall_cycles = 0;
    if_ce = 1; if_addr = 32'h0000_0100;
    #1;
    stall_cycles += int'(if_stallreq_o);
    tick();
    checks++;
    if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h0000_0100}) begin
      errors++;
      $display("FAIL fetch_bus: got req=%b we=%b sel=%h addr=%h, expected 1 0 f 00000100",
               bus_req_o, bus_we_o, bus_sel_o, bus_addr_o);
    end
    stall_cycles += int'(if_stallreq_o);
    tick();
    stall_cycles += int'(if_stallreq_o);
    tick();
    stall_cycles += int'(if_stallreq_o);
    bus_ack = 1; bus_rdata = 32'h3C01_0001;
    tick();
    bus_ack = 0;
    checks++;
    if (stall_cycles !== 4) begin
      errors++;
      $display("FAIL fetch_stall_cycles: got %0d, expected 4", stall_cycles);
    end
    checks++;
    if ({if_stallreq_o, if_rdata_o, bus_req_o} !== {1'b0, 32'h3C01_0001, 1'b0}) begin
      errors++;
      $display("FAIL fetch_result: got stall=%b rdata=%h req=%b, expected 0 3c010001 0",
               if_stallreq_o, if_rdata_o, bus_req_o);
    end
    if_ce = 0;
    tick();
    checks++;
    if ({if_stallreq_o, bus_req_o} !== 2'b00) begin
      errors++;
      $display("FAIL fetch_no_refetch: got stall=%b req=%b, expected 0 0", if_stallreq_o, bus_req_o);
    end
  endtask

  task automatic test_priority();
    if_ce = 1; if_addr = 32'h0000_0104;
    mem_ce = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h0000_0200;
    #1;
    checks++;
    if ({mem_stallreq_o, if_stallreq_o} !== 2'b11) begin
      errors++;
      $display("FAIL prio_both_stall: got %b, expected 11", {mem_stallreq_o, if_stallreq_o});
    end
    tick();
    checks++;
    if ({bus_req_o, bus_we_o, bus_addr_o} !== {1'b1, 1'b0, 32'h0000_0200}) begin
      errors++;
      $display("FAIL prio_grant_data: got req=%b we=%b addr=%h, expected 1 0 00000200",
               bus_req_o, bus_we_o, bus_addr_o);
    end
    tick();
    checks++;
    if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h0000_0200}) begin
      errors++;
      $display("FAIL prio_addr_held: got req=%b addr=%h, expected 1 00000200", bus_req_o, bus_addr_o);
    end
    bus_ack = 1; bus_rdata = 32'h1111_2222;
    tick();
    bus_ack = 0;
    checks++;
    if ({mem_stallreq_o, if_stallreq_o, bus_req_o, mem_rdata_o} !== {3'b010, 32'h1111_2222}) begin
      errors++;
      $display("FAIL prio_mem_first: got mstall=%b istall=%b req=%b mrdata=%h, expected 0 1 0 11112222",
               mem_stallreq_o, if_stallreq_o, bus_req_o, mem_rdata_o);
    end
    mem_ce = 0;
    tick();
    checks++;
    if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h0000_0104}) begin
      errors++;
      $display("FAIL prio_grant_inst: got req=%b we=%b sel=%h addr=%h, expected 1 0 f 00000104",
               bus_req_o, bus_we_o, bus_sel_o, bus_addr_o);
    end
    bus_ack = 1; bus_rdata = 32'hAAAA_5555;
    tick();
    bus_ack = 0;
    checks++;
    if ({if_stallreq_o, if_rdata_o} !== {1'b0, 32'hAAAA_5555}) begin
      errors++;
      $display("FAIL prio_inst_done: got stall=%b rdata=%h, expected 0 aaaa5555", if_stallreq_o, if_rdata_o);
    end
    if_ce = 0;
    tick();
  endtask

  task automatic test_store();
    mem_ce = 1; mem_we = 1; mem_sel = 4'b0100; mem_addr = 32'h0000_0300; mem_wdata = 32'h00AB_0000;
    tick();
    checks++;
    if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o} !==
        {1'b1, 1'b1, 4'b0100, 32'h0000_0300, 32'h00AB_0000}) begin
      errors++;
      $display("FAIL store_bus: got req=%b we=%b sel=%b addr=%h wdata=%h, expected 1 1 0100 00000300 00ab0000",
               bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o);
    end
    mem_wdata = 32'hFFFF_FFFF;
    tick();
    checks++;
    if ({bus_we_o, bus_sel_o, bus_wdata_o} !== {1'b1, 4'b0100, 32'h00AB_0000}) begin
      errors++;
      $display("FAIL store_held: got we=%b sel=%b wdata=%h, expected 1 0100 00ab0000",
               bus_we_o, bus_sel_o, bus_wdata_o);
    end
    bus_ack = 1; bus_rdata = 32'h9999_9999;
    tick();
    bus_ack = 0;
    checks++;
    if ({mem_stallreq_o, bus_req_o, mem_rdata_o} !== {2'b00, 32'h1111_2222}) begin
      errors++;
      $display("FAIL store_done: got stall=%b req=%b mrdata=%h, expected 0 0 11112222",
               mem_stallreq_o, bus_req_o, mem_rdata_o);
    end
    mem_ce = 0; mem_we = 0;
    tick();
  endtask

  task automatic test_hold();
    if_ce = 1; if_addr = 32'h0000_0108;
    tick();
    bus_ack = 1; bus_rdata = 32'h2402_0005;
    tick();
    bus_ack = 0;
    checks++;
    if ({if_stallreq_o, if_rdata_o} !== {1'b0, 32'h2402_0005}) begin
      errors++;
      $display("FAIL hold_fetch: got stall=%b rdata=%h, expected 0 24020005", if_stallreq_o, if_rdata_o);
    end
    pipe_hold = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({if_stallreq_o, bus_req_o, if_rdata_o} !== {2'b00, 32'h2402_0005}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got stall=%b req=%b rdata=%h, expected 0 0 24020005",
                 i, if_stallreq_o, bus_req_o, if_rdata_o);
      end
    end
    pipe_hold = 0;
    tick();
    checks++;
    if ({if_stallreq_o, bus_req_o} !== 2'b10) begin
      errors++;
      $display("FAIL hold_consumed: got stall=%b req=%b, expected 1 0", if_stallreq_o, bus_req_o);
    end
    if_ce = 0;
    tick();
  endtask

  task automatic test_flush();
    if_ce = 1; if_addr = 32'h0000_010C;
    tick();
    checks++;
    if (bus_req_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_granted: got req=%b, expected 1", bus_req_o);
    end
    flush = 1;
    tick();
    flush = 0;
    tick();
    bus_ack = 1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_ack = 0;
    checks++;
    if ({if_stallreq_o, bus_req_o, if_rdata_o} !== {2'b10, 32'h2402_0005}) begin
      errors++;
      $display("FAIL flush_discard: got stall=%b req=%b rdata=%h, expected 1 0 24020005",
               if_stallreq_o, bus_req_o, if_rdata_o);
    end
    tick();
    checks++;
    if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h0000_010C}) begin
      errors++;
      $display("FAIL flush_reissue: got req=%b addr=%h, expected 1 0000010c", bus_req_o, bus_addr_o);
    end
    bus_ack = 1; bus_rdata = 32'h8C22_0000;
    tick();
    bus_ack = 0;
    checks++;
    if ({if_stallreq_o, if_rdata_o} !== {1'b0, 32'h8C22_0000}) begin
      errors++;
      $display("FAIL flush_refetch_done: got stall=%b rdata=%h, expected 0 8c220000", if_stallreq_o, if_rdata_o);
    end
    if_ce = 0;
    tick();
  endtask

  task automatic test_timeout();
    mem_ce = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h0000_0400;
    tick(); tick(); tick(); tick();
    checks++;
    if ({bus_req_o, bus_err_o} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_waiting: got req=%b err=%b, expected 1 0", bus_req_o, bus_err_o);
    end
    tick();
`ifdef MEM_BUS_ARB_TIMEOUT_EN
    checks++;
    if ({bus_err_o, bus_req_o, mem_stallreq_o, mem_rdata_o} !== {3'b100, 32'h0}) begin
      errors++;
      $display("FAIL timeout_fire: got err=%b req=%b stall=%b mrdata=%h, expected 1 0 0 00000000",
               bus_err_o, bus_req_o, mem_stallreq_o, mem_rdata_o);
    end
    mem_ce = 0;
    tick();
    checks++;
    if ({bus_err_o, bus_req_o} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_pulse: got err=%b req=%b, expected 0 0", bus_err_o, bus_req_o);
    end
`else
    checks++;
    if ({bus_err_o, bus_req_o, mem_stallreq_o} !== 3'b011) begin
      errors++;
      $display("FAIL no_timeout_wait: got err=%b req=%b stall=%b, expected 0 1 1",
               bus_err_o, bus_req_o, mem_stallreq_o);
    end
    bus_ack = 1; bus_rdata = 32'h0BAD_F00D;
    tick();
    bus_ack = 0;
    checks++;
    if ({mem_stallreq_o, mem_rdata_o} !== {1'b0, 32'h0BAD_F00D}) begin
      errors++;
      $display("FAIL no_timeout_ack: got stall=%b mrdata=%h, expected 0 0badf00d", mem_stallreq_o, mem_rdata_o);
    end
    mem_ce = 0;
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_priority();
    test_store();
    test_hold();
    test_flush();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not complete within 50000 time units");
    $fatal(1);
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-ported, multi-cycle memory bus between instruction fetch (IF) and the MEM-stage load/store port.
- Sequences each access as a request/ack handshake and latches the read result.
- Drives per-requester stall requests to the pipeline controller.
- Sits between the IF/MEM stages and the external SRAM/bus wrapper. Byte-lane select and write data arrive already aligned from MEM.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Select width is DATA_W/8.
- TIMEOUT_CYC, 255, maximum cycles to wait for bus_ack_i. Used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- if_ce_i  in  1  fetch request
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched instruction
- if_stallreq_o  out  1  fetch not yet complete
- mem_ce_i  in  1  data request
- mem_we_i  in  1  1 = store
- mem_sel_i  in  DATA_W/8  byte lanes
- mem_addr_i  in  ADDR_W  data address
- mem_wdata_i  in  DATA_W  store data
- mem_rdata_o  out  DATA_W  load data
- mem_stallreq_o  out  1  data access not yet complete
- pipe_hold_i  in  1  pipeline frozen this cycle by another cause
- flush_i  in  1  exception flush
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write
- bus_sel_o  out  DATA_W/8  bus byte lanes
- bus_addr_o  out  ADDR_W  bus address
- bus_wdata_o  out  DATA_W  bus write data
- bus_rdata_i  in  DATA_W  bus read data
- bus_ack_i  in  1  transfer complete
- bus_err_o  out  1  timeout pulse (optional feature)

Behaviour:
- Reset: state IDLE, discard flag = 0.
  - All bus_* outputs = 0.
  - if_rdata_o = mem_rdata_o = 0, both result-valid flags = 0, both stallreq = 0.
  - Reset mid-transfer abandons the transfer. A late bus_ack_i is ignored in IDLE.
- FSM states: IDLE, DATA, INST.
- IDLE:
  - A requester is pending when its ce_i = 1 and its result-valid flag = 0.
  - If MEM is pending → DATA. Else if IF is pending → INST. MEM always wins (older instruction).
  - On the transition edge, capture address, we, sel and wdata into bus registers and set bus_req_o = 1.
  - IF requests use we = 0, sel = all ones.
- DATA / INST:
  - Bus outputs stay constant until bus_ack_i.
  - On the ack edge: bus_req_o → 0, return to IDLE.
  - Unless discard = 1, load bus_rdata_i into the matching rdata register and set its valid flag. Stores set valid only; mem_rdata_o is unchanged.
  - Minimum occupancy is 1 cycle per transfer. No back-to-back issue in the ack cycle.
  - Next grant decision is made in IDLE the following cycle.
- Stall outputs (combinational): xx_stallreq_o = xx_ce_i & ~xx_valid.
  - Example: a 1-cycle-ack load starting from IDLE stalls MEM for exactly 2 cycles.
- Result consumption: at each edge with pipe_hold_i = 0, a valid flag that was 1 clears to 0, so each result is used once.
  - With pipe_hold_i = 1, valid flags and rdata registers hold.
- flush_i:
  - Clears both valid flags.
  - If in DATA or INST, sets discard. The transfer still runs to ack; its result is dropped.
  - discard clears on the ack edge.
  - Exception: a store already on the bus completes its write (cannot be retracted).
- ce_i dropping mid-transfer: the transfer completes and the result is latched. A valid flag whose ce_i is 0 clears at the next non-held edge.
- Address / sel legality is MEM's responsibility. The arbiter passes values unchanged.

Optional Feature:
- Macro: MEM_BUS_ARB_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter resets on grant and increments each cycle in DATA/INST.
  - On reaching TIMEOUT_CYC without ack: return to IDLE, drop bus_req_o.
  - The requester's rdata register loads 0 and its valid flag sets.
  - bus_err_o pulses 1 for one cycle.
- When undefined: no counter, bus_err_o tied 0, wait for ack indefinitely.

Decomposition:
- Shared define file:
  - FSM state encodings ARB_IDLE/ARB_DATA/ARB_INST.
  - Existing RstEnable, ChipEnable, WriteEnable, ZeroWord reused.
  - Default TIMEOUT_CYC constant.
- Sub-module mem_bus_result_reg: one instance per requester, holds rdata + valid with load/clear/hold controls.

Test Plan:
- Lone fetch, addr 0x100, ack after 3 cycles, rdata 0x3C010001 → if_stallreq_o high 4 cycles; if_rdata_o = 0x3C010001 with stall low for 1 cycle.
- Simultaneous if_ce_i and mem_ce_i (LW 0x200) → DATA granted first; bus_addr_o = 0x200 until ack; then INST; mem_stallreq_o drops before if_stallreq_o.
- SB, sel 4'b0100, wdata 0x00AB0000 → bus_we_o = 1, bus_sel_o = 0100, bus_wdata_o = 0x00AB0000 held until ack; mem_rdata_o unchanged.
- pipe_hold_i = 1 for 3 cycles after fetch completes → if_rdata_o and valid held; stall stays low; consumed on first edge with hold = 0.
- flush_i during INST, ack 2 cycles later with 0xDEADBEEF → result discarded, valid = 0; next fetch re-issues.
- Timeout macro, TIMEOUT_CYC = 4, no ack → bus_err_o pulses after 4 cycles; mem_rdata_o = 0; FSM back to IDLE; without macro, still waiting.
